// File: rtl/grostl_ctrl_pkg.sv
// Shared types and constants for the serial Grostl-256 compression sequencer.
package grostl_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_P,
        ST_XOR,
        ST_PERM_P,
        ST_FOLD_P,
        ST_LOAD_Q,
        ST_PERM_Q,
        ST_FOLD_Q,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_M_IN  = 2'b00;
    localparam logic [1:0] SEL_M_RND = 2'b01;
    localparam logic [1:0] SEL_M_XOR = 2'b10;

    localparam int unsigned ROUNDS_DEFAULT = 10;
    localparam int unsigned COLS_DEFAULT   = 8;
    localparam int unsigned RND_W          = 4;
    localparam int unsigned COL_W          = 3;

endpackage

// File: rtl/grostl_rnd_cnt.sv
// Phase/column/round walker for one permutation; wraps to zero after its last step.
module grostl_rnd_cnt
    import grostl_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned COLS   = COLS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic             o_ph,
    output logic [RND_W-1:0] o_rnd,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic             r_ph;
    logic [RND_W-1:0] r_rnd;
    logic [COL_W-1:0] r_col;
    logic             w_col_end;
    logic             w_rnd_end;

    assign w_col_end = (r_col == COL_W'(COLS - 1));
    assign w_rnd_end = (r_rnd == RND_W'(ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph  <= 1'b0;
            r_rnd <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_ph  <= 1'b0;
            r_rnd <= '0;
            r_col <= '0;
        end else if (i_en) begin
            r_ph <= ~r_ph;
            if (r_ph) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_rnd <= w_rnd_end ? '0 : r_rnd + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign o_ph   = r_ph;
    assign o_rnd  = r_rnd;
    assign o_col  = r_col;
    assign o_last = r_ph && w_col_end && w_rnd_end;

endmodule

// File: rtl/grostl_ctrl_serial.sv
// Control sequencer for the serial masked Grostl-256 compression datapath.
module grostl_ctrl_serial
    import grostl_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned COLS   = COLS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       first,
    output logic       busy,
    output logic       done,
    output logic       wr_m,
    output logic       wr_h,
    output logic [1:0] sel_m,
    output logic       sel_h,
    output logic       sel_d,
    output logic       sel_pq,
    output logic [3:0] rnd,
    output logic [3-1:0] col
);

    state_t           r_state;
    state_t           w_next;
    logic             r_first;
    logic             w_ph;
    logic             w_last;
    logic             w_clr;
    logic             w_en;
    logic [RND_W-1:0] w_rnd;
    logic [COL_W-1:0] w_col;

    // Counter is zeroed in the state just before each PERM so both passes start at rnd 0.
    assign w_clr = (r_state == ST_XOR) || (r_state == ST_LOAD_Q);
    assign w_en  = (r_state == ST_PERM_P) || (r_state == ST_PERM_Q);

    grostl_rnd_cnt #(
        .ROUNDS(ROUNDS),
        .COLS  (COLS)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_ph  (w_ph),
        .o_rnd (w_rnd),
        .o_col (w_col),
        .o_last(w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_first <= first;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        wr_m   = 1'b0;
        wr_h   = 1'b0;
        sel_m  = SEL_M_RND;
        sel_h  = 1'b1;
        sel_d  = 1'b0;
        sel_pq = 1'b0;
        rnd    = w_rnd;
        col    = w_col;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD_P;
            end
            ST_LOAD_P: begin
                busy   = 1'b1;
                sel_m  = SEL_M_IN;
                wr_m   = 1'b1;
                if (r_first) begin
                    wr_h  = 1'b1;
                    sel_h = 1'b0;
                end
                w_next = ST_XOR;
            end
            ST_XOR: begin
                busy   = 1'b1;
                sel_m  = SEL_M_XOR;
                wr_m   = 1'b1;
                w_next = ST_PERM_P;
            end
            ST_PERM_P, ST_PERM_Q: begin
                busy   = 1'b1;
                sel_pq = (r_state == ST_PERM_Q);
                if (w_ph) begin
                    wr_m = 1'b1;
                end else begin
                    sel_d = (w_col == '0);
                end
                if (w_last) w_next = (r_state == ST_PERM_P) ? ST_FOLD_P : ST_FOLD_Q;
            end
            ST_FOLD_P: begin
                busy   = 1'b1;
                wr_h   = 1'b1;
                w_next = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                busy   = 1'b1;
                sel_m  = SEL_M_IN;
                wr_m   = 1'b1;
                w_next = ST_PERM_Q;
            end
            ST_FOLD_Q: begin
                busy   = 1'b1;
                sel_m  = SEL_M_XOR;
                wr_m   = 1'b1;
                wr_h   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_grostl_ctrl_serial.sv
// Directed self-checking bench for grostl_ctrl_serial; cycle n is the period after start edge n.
module tb_grostl_ctrl_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       first;
    logic       busy;
    logic       done;
    logic       wr_m;
    logic       wr_h;
    logic [1:0] sel_m;
    logic       sel_h;
    logic       sel_d;
    logic       sel_pq;
    logic [3:0] rnd;
    logic [2:0] col;

    int checks;
    int errors;

    // Captured per cycle: {busy,done,wr_m,wr_h,sel_m,sel_h,sel_d,rnd,col}
    logic [14:0] cap_v  [0:699];
    logic        cap_pq [0:699];

    grostl_ctrl_serial #(
        .ROUNDS(10),
        .COLS  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .first (first),
        .busy  (busy),
        .done  (done),
        .wr_m  (wr_m),
        .wr_h  (wr_h),
        .sel_m (sel_m),
        .sel_h (sel_h),
        .sel_d (sel_d),
        .sel_pq(sel_pq),
        .rnd   (rnd),
        .col   (col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] exp_vec(input int c, input bit f);
        logic       b, d, wm, wh, sh, sd;
        logic [1:0] sm;
        logic [3:0] r;
        logic [2:0] k;
        int         p;
        b = 1'b0; d = 1'b0; wm = 1'b0; wh = 1'b0;
        sm = 2'b01; sh = 1'b1; sd = 1'b0; r = 4'd0; k = 3'd0;
        p = -1;
        if (c >= 1 && c <= 325) b = 1'b1;
        if (c == 1) begin
            sm = 2'b00; wm = 1'b1;
            if (f) begin wh = 1'b1; sh = 1'b0; end
        end
        if (c == 2)   begin sm = 2'b10; wm = 1'b1; end
        if (c >= 3 && c <= 162)   p = c - 3;
        if (c >= 165 && c <= 324) p = c - 165;
        if (p >= 0) begin
            k = 3'((p / 2) % 8);
            r = 4'(p / 16);
            if (p % 2 == 0) sd = (k == 3'd0);
            else            wm = 1'b1;
        end
        if (c == 163) wh = 1'b1;
        if (c == 164) begin sm = 2'b00; wm = 1'b1; end
        if (c == 325) begin sm = 2'b10; wm = 1'b1; wh = 1'b1; end
        if (c == 326) d = 1'b1;
        return {b, d, wm, wh, sm, sh, sd, r, k};
    endfunction

    task automatic launch(input bit f, input bit hold);
        @(negedge clk);
        start = 1'b1;
        first = f;
        @(posedge clk);
        #1;
        start = hold;
        first = 1'b0;
    endtask

    task automatic capture(input int n, input bit hold, input int pulse_c);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_v[c]  = {busy, done, wr_m, wr_h, sel_m, sel_h, sel_d, rnd, col};
            cap_pq[c] = sel_pq;
            start = (c < n) && (hold || c == pulse_c);
            first = (c == pulse_c);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        first = 1'b0;
        #12;
        checks++;
        if ({busy, done, wr_m, wr_h, sel_m, sel_h, sel_d, sel_pq, rnd, col} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_outputs got %b", {busy, done, wr_m, wr_h, sel_m, sel_h, sel_d, sel_pq, rnd, col});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, wr_m, wr_h, sel_m, rnd, col} !== {4'b0000, 2'b01, 4'd0, 3'd0}) begin
                errors++;
                $display("FAIL idle_hold cyc %0d got %b", i, {busy, done, wr_m, wr_h, sel_m, rnd, col});
            end
        end
    endtask

    task automatic test_first1;
        int nwh;
        launch(1'b1, 1'b0);
        capture(330, 1'b0, -1);
        checks++;
        if ({cap_v[1][12], cap_v[1][11], cap_v[1][8], cap_v[1][10:9]} !== 5'b11000) begin
            errors++;
            $display("FAIL load_p_first1 got %b exp 11000", {cap_v[1][12], cap_v[1][11], cap_v[1][8], cap_v[1][10:9]});
        end
        checks++;
        if (cap_v[2][10:9] !== 2'b10) begin
            errors++;
            $display("FAIL xor_sel_m got %b exp 10", cap_v[2][10:9]);
        end
        checks++;
        if ({cap_v[3][7], cap_v[3][2:0]} !== 4'b1000) begin
            errors++;
            $display("FAIL perm_entry got %b exp 1000", {cap_v[3][7], cap_v[3][2:0]});
        end
        checks++;
        if (cap_v[66][6:0] !== {4'd3, 3'd7}) begin
            errors++;
            $display("FAIL walk_r3c7 got %h exp %h", cap_v[66][6:0], {4'd3, 3'd7});
        end
        checks++;
        if ({cap_v[67][7], cap_v[67][6:0]} !== {1'b1, 4'd4, 3'd0}) begin
            errors++;
            $display("FAIL walk_r4c0 got %h exp %h", {cap_v[67][7], cap_v[67][6:0]}, {1'b1, 4'd4, 3'd0});
        end
        checks++;
        if ({cap_v[162][6:0], cap_v[163][6:0]} !== {4'd9, 3'd7, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL perm_p_exit got %h", {cap_v[162][6:0], cap_v[163][6:0]});
        end
        nwh = 0;
        for (int c = 1; c <= 330; c++) begin
            if (cap_v[c][11] === 1'b1) nwh++;
            checks++;
            if (cap_v[c] !== exp_vec(c, 1'b1)) begin
                errors++;
                $display("FAIL seq_first1 cyc %0d got %b exp %b", c, cap_v[c], exp_vec(c, 1'b1));
            end
            if ((c >= 3 && c <= 162) || (c >= 165 && c <= 324)) begin
                checks++;
                if (cap_pq[c] !== (c >= 165)) begin
                    errors++;
                    $display("FAIL sel_pq cyc %0d got %b exp %b", c, cap_pq[c], (c >= 165));
                end
            end
        end
        checks++;
        if (nwh != 3) begin
            errors++;
            $display("FAIL wr_h_count_first1 got %0d exp 3", nwh);
        end
    endtask

    task automatic test_first0;
        int nwh;
        launch(1'b0, 1'b0);
        capture(330, 1'b0, -1);
        checks++;
        if ({cap_v[1][11], cap_v[1][8]} !== 2'b01) begin
            errors++;
            $display("FAIL load_p_first0 got %b exp 01", {cap_v[1][11], cap_v[1][8]});
        end
        nwh = 0;
        for (int c = 1; c <= 330; c++) begin
            if (cap_v[c][11] === 1'b1) nwh++;
            checks++;
            if (cap_v[c] !== exp_vec(c, 1'b0)) begin
                errors++;
                $display("FAIL seq_first0 cyc %0d got %b exp %b", c, cap_v[c], exp_vec(c, 1'b0));
            end
        end
        checks++;
        if (nwh != 2 || cap_v[163][11] !== 1'b1 || cap_v[325][11] !== 1'b1) begin
            errors++;
            $display("FAIL wr_h_pulses_first0 got count %0d exp 2", nwh);
        end
    endtask

    task automatic test_ignore_start;
        int ndone;
        launch(1'b0, 1'b0);
        capture(330, 1'b0, 100);
        ndone = 0;
        for (int c = 1; c <= 330; c++) begin
            if (cap_v[c][13] === 1'b1) ndone++;
            checks++;
            if (cap_v[c] !== exp_vec(c, 1'b0)) begin
                errors++;
                $display("FAIL seq_ignore cyc %0d got %b exp %b", c, cap_v[c], exp_vec(c, 1'b0));
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL done_count_ignore got %0d exp 1", ndone);
        end
    endtask

    task automatic test_back_to_back;
        launch(1'b1, 1'b1);
        capture(654, 1'b1, -1);
        for (int c = 1; c <= 654; c++) begin
            checks++;
            if (cap_v[c] !== ((c <= 327) ? exp_vec(c, 1'b1) : exp_vec(c - 327, 1'b0))) begin
                errors++;
                $display("FAIL seq_b2b cyc %0d got %b", c, cap_v[c]);
            end
        end
        checks++;
        if ({cap_v[326][13], cap_v[327][14], cap_v[328][14], cap_v[653][13]} !== 4'b1011) begin
            errors++;
            $display("FAIL b2b_gap got %b exp 1011", {cap_v[326][13], cap_v[327][14], cap_v[328][14], cap_v[653][13]});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        launch(1'b1, 1'b0);
        repeat (200) @(negedge clk);
        checks++;
        if ({busy, wr_m, sel_pq} !== 3'b111) begin
            errors++;
            $display("FAIL pre_reset got %b exp 111", {busy, wr_m, sel_pq});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, wr_m, wr_h, sel_m, sel_pq, rnd, col} !== {4'b0000, 2'b01, 1'b0, 4'd0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset got %b", {busy, done, wr_m, wr_h, sel_m, sel_pq, rnd, col});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, wr_m, wr_h} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held got %b exp 000", {busy, wr_m, wr_h});
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(1'b1, 1'b0);
        capture(330, 1'b0, -1);
        for (int c = 1; c <= 330; c++) begin
            checks++;
            if (cap_v[c] !== exp_vec(c, 1'b1)) begin
                errors++;
                $display("FAIL seq_after_reset cyc %0d got %b exp %b", c, cap_v[c], exp_vec(c, 1'b1));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first1();
        test_first0();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
